cache_bank_dp: RTL and testbench
================================

Name: cache_bank_dp

Overview:
Parametrised dual-port cache data bank with a per-line written (valid) tracking array and registered read ports.
Both ports share one clock.
A sequential flush engine invalidates every line without touching data contents.
Sits under the cache controller as one bank of the set array and replaces the fixed-size single-generation bank.

Parameters:
DATA_WIDTH, 32, width of one cache line word
ADDR_WIDTH, 6, line address width
LINES, 2**ADDR_WIDTH, number of lines; must equal 2**ADDR_WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
flush  input  1  request to invalidate all lines; sampled only in IDLE
flushBusy  output  1  high while the flush sweep runs
cacheEnable_A  input  1  port A access enable, active-high
cacheAddressIn_A  input  ADDR_WIDTH  port A line address
cacheDataIn_A  input  DATA_WIDTH  port A write data
memWrite_A  input  1  active-low write strobe (0 = write, 1 = read)
cacheDataOut_A  output  DATA_WIDTH  port A registered read data
portA_writtenTo  output  1  registered written flag of the line port A accessed
(port B: cacheEnable_B, cacheAddressIn_B, cacheDataIn_B, memWrite_B, cacheDataOut_B, portB_writtenTo; same definitions)
writeCollision  output  1  registered pulse: both ports wrote the same address in one cycle

Behaviour:
- Reset (async, active-high):
  - state = IDLE, flush pointer = 0, all written bits = 0.
  - All outputs = 0.
  - Data array is not reset.
- Access: an access occurs on a rising edge when cacheEnable_x = 1 and state = IDLE.
- Read (memWrite_x = 1):
  - cacheDataOut_x <= mem[addr] and portx_writtenTo <= written[addr] on that edge (1-cycle latency).
  - Both outputs hold their values when no access occurs.
- Write (memWrite_x = 0):
  - mem[addr] <= data and written[addr] <= 1.
  - cacheDataOut_x holds its value; portx_writtenTo <= 1.
- Same-cycle read and write on different ports to the same address: read-before-write. The reader gets the old data and the old written bit; the new value is visible from the next access.
- Both ports write the same address in one cycle:
  - Port A wins; port B's data is dropped.
  - Both portx_writtenTo <= 1.
  - writeCollision = 1 for exactly one cycle, otherwise 0.
- Both ports read the same address: both return identical values, no collision.
- Flush FSM, states IDLE and FLUSH:
  - IDLE -> FLUSH on flush = 1. flushBusy goes high on that edge and the pointer is set to 0.
  - FLUSH: each cycle, written[ptr] <= 0 and ptr <= ptr + 1.
  - When ptr = LINES-1 that line is cleared, then state -> IDLE, flushBusy -> 0 and ptr -> 0.
  - A flush of LINES lines keeps flushBusy high for exactly LINES cycles.
  - During FLUSH all port accesses are ignored: writes are dropped, outputs hold, and writeCollision = 0.
  - flush asserted while in FLUSH is ignored (no restart). A flush held high in the cycle the sweep ends starts a new sweep immediately.
  - A port access in the same cycle flush is sampled in IDLE is still performed; the sweep then clears its written bit.
- Reset mid-flush: immediate return to IDLE, all written bits cleared, pointer = 0.
- Address width arithmetic: the pointer is ADDR_WIDTH bits and end of sweep is detected by comparison, never by overflow.

Test Plan:
- Reset, then port A reads addr 5 -> next cycle cacheDataOut_A = 0 (after-reset hold), portA_writtenTo = 0.
- Port A writes 0xDEADBEEF to addr 3, then port B reads addr 3 -> one cycle later cacheDataOut_B = 0xDEADBEEF, portB_writtenTo = 1.
- Same cycle: A writes 0x11 and B writes 0x22, both to addr 7 -> writeCollision = 1 for 1 cycle; a later read of addr 7 returns 0x11.
- Same cycle: A writes 0x55 to addr 9 (old 0x44) and B reads addr 9 -> B gets 0x44; a B read next cycle gets 0x55.
- Write lines 0, 10, 63; pulse flush -> flushBusy high for 64 cycles and a port-A write issued mid-sweep is dropped; afterwards reads of 0, 10, 63 give writtenTo = 0 with data unchanged.
- Assert reset at sweep cycle 20 -> flushBusy = 0 immediately, all outputs 0; next flush sweeps a full 64 cycles.

Source files
------------

// File: rtl/cache_bank_dp.sv
// Dual-port cache data bank: one data array, a per-line written flag, registered
// read ports and a sequential flush engine that clears the written flags.
module cache_bank_dp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned LINES      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  output logic                  flushBusy,
  input  logic                  cacheEnable_A,
  input  logic [ADDR_WIDTH-1:0] cacheAddressIn_A,
  input  logic [DATA_WIDTH-1:0] cacheDataIn_A,
  input  logic                  memWrite_A,
  output logic [DATA_WIDTH-1:0] cacheDataOut_A,
  output logic                  portA_writtenTo,
  input  logic                  cacheEnable_B,
  input  logic [ADDR_WIDTH-1:0] cacheAddressIn_B,
  input  logic [DATA_WIDTH-1:0] cacheDataIn_B,
  input  logic                  memWrite_B,
  output logic [DATA_WIDTH-1:0] cacheDataOut_B,
  output logic                  portB_writtenTo,
  output logic                  writeCollision
);

  localparam logic [ADDR_WIDTH-1:0] LAST_LINE = ADDR_WIDTH'(LINES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] mem_q [LINES];
  logic [LINES-1:0]      written_q;

  logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;
  logic                  wt_a_q, wt_b_q;
  logic                  coll_q;

  logic idle_c, acc_a_c, acc_b_c, rd_a_c, rd_b_c, wr_a_c, wr_b_c, collide_c, wr_b_eff_c;

  // Port accesses are only honoured while the flush engine is idle
  always_comb begin
    idle_c     = (state_q == IDLE);
    acc_a_c    = cacheEnable_A & idle_c;
    acc_b_c    = cacheEnable_B & idle_c;
    rd_a_c     = acc_a_c & memWrite_A;
    rd_b_c     = acc_b_c & memWrite_B;
    wr_a_c     = acc_a_c & ~memWrite_A;
    wr_b_c     = acc_b_c & ~memWrite_B;
    collide_c  = wr_a_c & wr_b_c & (cacheAddressIn_A == cacheAddressIn_B);
    wr_b_eff_c = wr_b_c & ~collide_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Sweep ends by comparison on the last line; a held flush re-arms immediately
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      FLUSH: begin
        if (ptr_q == LAST_LINE) begin
          ptr_d = '0;
          if (flush) begin
            state_d = FLUSH;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
    endcase
  end

  // Data array is not reset; port A wins a same-address write collision
  always_ff @(posedge clk) begin
    if (wr_b_eff_c) mem_q[cacheAddressIn_B] <= cacheDataIn_B;
    if (wr_a_c)     mem_q[cacheAddressIn_A] <= cacheDataIn_A;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      written_q <= '0;
    end else begin
      if (state_q == FLUSH) written_q[ptr_q] <= 1'b0;
      if (wr_a_c)           written_q[cacheAddressIn_A] <= 1'b1;
      if (wr_b_c)           written_q[cacheAddressIn_B] <= 1'b1;
    end
  end

  // Registered read ports; reads see pre-write contents of this edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
      wt_a_q   <= 1'b0;
      wt_b_q   <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      if (rd_a_c)  dout_a_q <= mem_q[cacheAddressIn_A];
      if (rd_b_c)  dout_b_q <= mem_q[cacheAddressIn_B];
      if (acc_a_c) wt_a_q   <= memWrite_A ? written_q[cacheAddressIn_A] : 1'b1;
      if (acc_b_c) wt_b_q   <= memWrite_B ? written_q[cacheAddressIn_B] : 1'b1;
      coll_q <= collide_c;
    end
  end

  assign flushBusy       = busy_q;
  assign cacheDataOut_A  = dout_a_q;
  assign cacheDataOut_B  = dout_b_q;
  assign portA_writtenTo = wt_a_q;
  assign portB_writtenTo = wt_b_q;
  assign writeCollision  = coll_q;

endmodule

// File: tb/tb_cache_bank_dp.sv
// Self-checking bench for cache_bank_dp: directed scenarios plus random traffic
// compared each cycle against an array-based reference model.
module tb_cache_bank_dp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;
  localparam int unsigned NL = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          flushBusy;
  logic          cacheEnable_A = 1'b0, cacheEnable_B = 1'b0;
  logic [AW-1:0] cacheAddressIn_A = '0, cacheAddressIn_B = '0;
  logic [DW-1:0] cacheDataIn_A = '0, cacheDataIn_B = '0;
  logic          memWrite_A = 1'b1, memWrite_B = 1'b1;
  logic [DW-1:0] cacheDataOut_A, cacheDataOut_B;
  logic          portA_writtenTo, portB_writtenTo, writeCollision;

  cache_bank_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINES(NL)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flushBusy(flushBusy),
    .cacheEnable_A(cacheEnable_A), .cacheAddressIn_A(cacheAddressIn_A),
    .cacheDataIn_A(cacheDataIn_A), .memWrite_A(memWrite_A),
    .cacheDataOut_A(cacheDataOut_A), .portA_writtenTo(portA_writtenTo),
    .cacheEnable_B(cacheEnable_B), .cacheAddressIn_B(cacheAddressIn_B),
    .cacheDataIn_B(cacheDataIn_B), .memWrite_B(memWrite_B),
    .cacheDataOut_B(cacheDataOut_B), .portB_writtenTo(portB_writtenTo),
    .writeCollision(writeCollision)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: line contents, written flags, remaining sweep cycles
  logic [DW-1:0] m_mem [NL];
  bit            m_wr  [NL];
  int            m_left = 0;
  int            m_idx  = 0;
  logic [DW-1:0] e_da = '0, e_db = '0;
  bit            e_wa = 0, e_wb = 0, e_col = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input bit en, input bit rd, input int addr, input logic [DW-1:0] d);
    cacheEnable_A = en; memWrite_A = rd; cacheAddressIn_A = AW'(addr); cacheDataIn_A = d;
  endtask

  task automatic drive_b(input bit en, input bit rd, input int addr, input logic [DW-1:0] d);
    cacheEnable_B = en; memWrite_B = rd; cacheAddressIn_B = AW'(addr); cacheDataIn_B = d;
  endtask

  task automatic idle_inputs();
    drive_a(0, 1, 0, '0);
    drive_b(0, 1, 0, '0);
    flush = 1'b0;
  endtask

  // Advance one clock: update the model from the current inputs, then compare
  task automatic step();
    int  aa, ab;
    bit  wa, wb;
    aa = int'(cacheAddressIn_A);
    ab = int'(cacheAddressIn_B);
    if (m_left == 0) begin
      wa = cacheEnable_A && !memWrite_A;
      wb = cacheEnable_B && !memWrite_B;
      if (cacheEnable_A && memWrite_A) begin e_da = m_mem[aa]; e_wa = m_wr[aa]; end
      if (cacheEnable_B && memWrite_B) begin e_db = m_mem[ab]; e_wb = m_wr[ab]; end
      if (wa) e_wa = 1;
      if (wb) e_wb = 1;
      e_col = wa && wb && (aa == ab);
      if (wb && !e_col) begin m_mem[ab] = cacheDataIn_B; m_wr[ab] = 1; end
      if (wa) begin m_mem[aa] = cacheDataIn_A; m_wr[aa] = 1; end
      if (flush) begin m_left = NL; m_idx = 0; end
    end else begin
      e_col = 0;
      m_wr[m_idx] = 0;
      m_idx++;
      m_left--;
      if (m_left == 0 && flush) begin m_left = NL; m_idx = 0; end
    end
    @(posedge clk); #1;
    check("dout_a", cacheDataOut_A, e_da);
    check("dout_b", cacheDataOut_B, e_db);
    check("wt_a", 32'(portA_writtenTo), 32'(e_wa));
    check("wt_b", 32'(portB_writtenTo), 32'(e_wb));
    check("coll", 32'(writeCollision), 32'(e_col));
    check("busy", 32'(flushBusy), 32'(m_left > 0));
  endtask

  // Async reset between clock edges; outputs must clear without a clock
  task automatic do_reset();
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    check("rst_dout_a", cacheDataOut_A, '0);
    check("rst_dout_b", cacheDataOut_B, '0);
    check("rst_wt_a", 32'(portA_writtenTo), 0);
    check("rst_wt_b", 32'(portB_writtenTo), 0);
    check("rst_coll", 32'(writeCollision), 0);
    check("rst_busy", 32'(flushBusy), 0);
    for (int i = 0; i < NL; i++) m_wr[i] = 0;
    e_da = '0; e_db = '0; e_wa = 0; e_wb = 0; e_col = 0;
    m_left = 0; m_idx = 0;
    #1 reset = 1'b0;
  endtask

  // Pulse flush and count busy cycles; optionally try a port-A write mid-sweep
  task automatic flush_sweep(input int write_at, input int waddr);
    int cnt;
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    cnt = 1;
    for (int k = 1; k < 200; k++) begin
      if (k == write_at) drive_a(1, 0, waddr, $urandom());
      else drive_a(0, 1, 0, '0);
      step();
      if (!flushBusy) break;
      cnt++;
    end
    check("busy_len", 32'(cnt), 32'(NL));
    idle_inputs();
  endtask

  initial begin
    do_reset();
    step();

    // Preload every line with known data (line 5 gets zero), then reset
    for (int i = 0; i < NL; i++) begin
      drive_a(1, 0, i, (i == 5) ? 32'h0 : $urandom());
      step();
    end
    do_reset();
    drive_a(1, 1, 5, '0);
    step();
    check("rd5_data", cacheDataOut_A, 32'h0);
    check("rd5_wt", 32'(portA_writtenTo), 0);

    // Write then read on the other port
    drive_a(1, 0, 3, 32'hDEADBEEF); idle_inputs(); drive_a(1, 0, 3, 32'hDEADBEEF);
    step();
    idle_inputs(); drive_b(1, 1, 3, '0);
    step();
    check("wr_rd_b", cacheDataOut_B, 32'hDEADBEEF);
    check("wr_rd_wt", 32'(portB_writtenTo), 1);

    // Same-address write collision: A wins, one-cycle pulse
    drive_a(1, 0, 7, 32'h11); drive_b(1, 0, 7, 32'h22);
    step();
    check("coll_pulse", 32'(writeCollision), 1);
    idle_inputs(); drive_a(1, 1, 7, '0);
    step();
    check("coll_clear", 32'(writeCollision), 0);
    check("coll_data", cacheDataOut_A, 32'h11);

    // Read-before-write across ports
    drive_a(1, 0, 9, 32'h44); drive_b(0, 1, 0, '0);
    step();
    drive_a(1, 0, 9, 32'h55); drive_b(1, 1, 9, '0);
    step();
    check("rbw_old", cacheDataOut_B, 32'h44);
    idle_inputs(); drive_b(1, 1, 9, '0);
    step();
    check("rbw_new", cacheDataOut_B, 32'h55);

    // Both ports read the same line
    drive_a(1, 1, 3, '0); drive_b(1, 1, 3, '0);
    step();
    check("dual_rd", cacheDataOut_A, cacheDataOut_B === 32'hDEADBEEF ? 32'hDEADBEEF : 32'hFFFF_FFFF);

    // Full flush with a dropped mid-sweep write
    idle_inputs();
    foreach (m_wr[i]) if (i == 0 || i == 10 || i == 63) begin
      drive_a(1, 0, i, $urandom()); step();
    end
    flush_sweep(30, 20);
    foreach (m_wr[i]) if (i == 0 || i == 10 || i == 63 || i == 20) begin
      drive_a(1, 1, i, '0); step();
      check("flush_wt0", 32'(portA_writtenTo), 0);
    end
    idle_inputs();

    // Reset at sweep cycle 20, then a full sweep again
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 1; k < 20; k++) step();
    do_reset();
    step();
    flush_sweep(-1, 0);

    // Random traffic over a narrow address range to provoke collisions
    for (int n = 0; n < 1500; n++) begin
      drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom());
      drive_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom());
      flush = ($urandom_range(0, 79) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
